// File: rtl/elastic_fifo.sv
// Valid/ready elastic buffer: DEPTH-entry circular buffer with flush, occupancy,
// almost-full and high-water mark. Define ELASTIC_FIFO_BYPASS_EN for zero-latency empty bypass.
module elastic_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int LW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [LW-1:0]         level,
  output logic                  almost_full,
  output logic [LW-1:0]         max_level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_THR = LW'(AF_LEVEL);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [LW-1:0]         r_count;
  logic                  r_af;
  logic [LW-1:0]         r_max;

  logic          w_bypass;
  logic          w_enq;
  logic          w_deq;
  logic          w_wr_en;
  logic          w_rd_adv;
  logic [LW-1:0] w_count_nxt;
  logic [LW-1:0] w_max_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

`ifdef ELASTIC_FIFO_BYPASS_EN
  assign w_bypass = (r_count == '0) && !flush && s_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign s_ready = (r_count != FULL) && !flush;
  assign m_valid = ((r_count != '0) && !flush) || w_bypass;
  assign m_data  = w_bypass ? s_data : r_mem[r_rd_ptr];

  assign w_enq = s_valid && s_ready;
  assign w_deq = m_valid && m_ready;
  // A bypassed word that is consumed immediately never touches storage.
  assign w_wr_en  = w_enq && !(w_bypass && m_ready);
  assign w_rd_adv = w_deq && !w_bypass;

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_wr_en, w_rd_adv})
        2'b10:   w_count_nxt = r_count + LW'(1);
        2'b01:   w_count_nxt = r_count - LW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_comb begin
    w_max_nxt = r_max;
    if (flush) begin
      w_max_nxt = '0;
    end else if (w_count_nxt > r_max) begin
      w_max_nxt = w_count_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_af     <= 1'b0;
      r_max    <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_af    <= (w_count_nxt >= AF_THR);
      r_max   <= w_max_nxt;
      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_wr_en) begin
          r_mem[r_wr_ptr] <= s_data;
          r_wr_ptr        <= ptr_inc(r_wr_ptr);
        end
        if (w_rd_adv) begin
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
      end
    end
  end

  assign level       = r_count;
  assign almost_full = r_af;
  assign max_level   = r_max;

endmodule

// File: doc/elastic_fifo.md
Name: elastic_fifo

Overview:
Parametrised valid/ready elastic buffer and the successor to the two-entry skid buffer. Generalised to DEPTH entries held in a circular buffer, with a synchronous flush, an occupancy output, a programmable almost-full flag and a high-water mark. Sits between pipeline stages on streaming datapaths that need more slack than two entries, or need back-pressure warning before the buffer is full.

Parameters:
DATA_WIDTH, 64, payload width in bits (>=1)
DEPTH, 4, number of entries (>=2; any integer, need not be a power of two)
AF_LEVEL, DEPTH-1, almost_full asserts when level >= AF_LEVEL (1..DEPTH)
LW, $clog2(DEPTH+1), width of level outputs (derived; do not override)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous discard of all entries
s_data  in  DATA_WIDTH  upstream payload
s_valid  in  1  upstream valid
s_ready  out  1  buffer can accept
m_data  out  DATA_WIDTH  downstream payload (head entry)
m_valid  out  1  head entry valid
m_ready  in  1  downstream accept
level  out  LW  current number of stored entries
almost_full  out  1  level >= AF_LEVEL
max_level  out  LW  high-water mark of level since reset/flush

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- State: storage array [DEPTH], rd_ptr, wr_ptr, count. All are registers and all are reset to 0, including storage.
- Reset values: s_ready=1, m_valid=0, m_data=0, level=0, almost_full=0, max_level=0.
- s_ready = (count != DEPTH) && !flush. No combinational path from m_ready to s_ready.
- m_valid = (count != 0) && !flush. m_data = storage[rd_ptr].
- enq = s_valid && s_ready; deq = m_valid && m_ready. A transfer occurs on a rising edge where the corresponding handshake holds.
- Latency: a write is visible at m_data/m_valid one cycle after acceptance (zero-latency bypass only with the optional feature).
- Per cycle, when flush=0:
  - enq only: write storage[wr_ptr]; wr_ptr advances; count+1.
  - deq only: rd_ptr advances; count-1.
  - both: write and advance both pointers; count unchanged. Allowed at any count 1..DEPTH-1. Not possible at full (s_ready=0) or empty (m_valid=0).
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0; no modulo-2^n assumption.
- flush=1: no transfer in that cycle. Next cycle rd_ptr=wr_ptr=count=0 and max_level=0. Storage contents are not cleared. flush takes priority over every handshake.
- level = count (registered). almost_full is registered, derived from next count, so it is valid in the same cycle as level.
- max_level <= max(max_level, next count) each cycle. It saturates at DEPTH.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight data is lost. No handshake completes on an edge while rst=1.
- s_valid may drop without a transfer; the buffer does not depend on AXI-style stability.

Optional Feature:
Macro ELASTIC_FIFO_BYPASS_EN.
- Defined: when count==0, flush=0 and s_valid=1, then m_valid=1 and m_data=s_data combinationally.
  - If m_ready=1, the word passes straight through: no write, count stays 0, max_level unchanged.
  - If m_ready=0, the word is written normally (count becomes 1).
  - This creates a combinational s_valid/s_data -> m_valid/m_data path; s_ready is still independent of m_ready.
- Undefined: no bypass; minimum latency is 1 cycle as described above.

Test Plan:
- Reset then idle: rst pulse with clk running -> s_ready=1, m_valid=0, m_data=0, level=0, max_level=0 during and after reset.
- Fill/drain, DEPTH=4, AF_LEVEL=3: write 0xA0..0xA3 with m_ready=0 -> level 1,2,3,4; almost_full rises with level=3; s_ready=0 at level 4; 5th word not accepted. Then m_ready=1 -> outputs A0,A1,A2,A3 in order; m_valid drops after A3; max_level=4.
- Wrap with DEPTH=3: continuous s_valid=m_ready=1 for 20 words 0..19 after pre-loading 1 word -> level stays 1 throughout; output order exact; pointers wrap 2->0 without loss.
- Random stall: 1000 words with random s_valid and m_ready at 50% -> scoreboard exact order, no drop or duplicate; level always equals accepted minus delivered.
- Flush at level 3 with s_valid=m_ready=1 -> no transfer that cycle; next cycle level=0, m_valid=0, max_level=0; next word accepted is the first one delivered.
- ELASTIC_FIFO_BYPASS_EN: empty buffer, s_valid=1, s_data=0x55, m_ready=1 -> m_valid=1 and m_data=0x55 in the same cycle, level stays 0. Repeat with m_ready=0 -> level=1 next cycle. Without the macro, the same stimulus gives m_valid only one cycle later.
